// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite definitions for bus masters and slaves.
//   htrans_e        : HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ)
//   hsize_e         : HSIZE encodings used here (BYTE/HALF/WORD)
//   AHB_ERR_FILLER  : read-data filler returned with an error response
//   clamp_size      : folds every HSIZE above WORD down to WORD
//   align_addr      : clears the address bits below the transfer size
// ---------------------------------------------------------------------------
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    localparam logic [31:0] AHB_ERR_FILLER = 32'hDEADBEEF;

    // The master only issues byte, halfword and word transfers; any wider
    // request is carried out as a word.
    function automatic logic [2:0] clamp_size(input logic [2:0] size);
        return (size > HSIZE_WORD) ? HSIZE_WORD : size;
    endfunction

    // The size passed in is expected to be clamped already.
    function automatic logic [31:0] align_addr(input logic [31:0] addr,
                                               input logic [2:0]  size);
        logic [31:0] aligned;
        case (size)
            HSIZE_BYTE: aligned = addr;
            HSIZE_HALF: aligned = {addr[31:1], 1'b0};
            default:    aligned = {addr[31:2], 2'b00};
        endcase
        return aligned;
    endfunction

endpackage

// File: rtl/ahb_lane_mux.sv
// ---------------------------------------------------------------------------
// ahb_lane_mux
// Purely combinational byte-lane steering for a 32-bit AHB master.
//   wr_size_i   : HSIZE of the write (BYTE/HALF/WORD)
//   wr_data_i   : right-justified write data
//   wr_lanes_o  : write data replicated across every lane it may occupy
//   rd_size_i   : HSIZE of the read
//   rd_offset_i : byte offset of the transfer inside the word (addr[1:0])
//   rd_lanes_i  : raw HRDATA
//   rd_data_o   : selected lane, right-justified and zero-extended
// ---------------------------------------------------------------------------
module ahb_lane_mux
    import ahb_pkg::*;
(
    input  logic [2:0]  wr_size_i,
    input  logic [31:0] wr_data_i,
    output logic [31:0] wr_lanes_o,
    input  logic [2:0]  rd_size_i,
    input  logic [1:0]  rd_offset_i,
    input  logic [31:0] rd_lanes_i,
    output logic [31:0] rd_data_o
);

    // Replicating the payload means the slave finds it on the right lane
    // whatever the address offset is, so no shifting is needed here.
    always_comb begin
        case (wr_size_i)
            HSIZE_BYTE: wr_lanes_o = {4{wr_data_i[7:0]}};
            HSIZE_HALF: wr_lanes_o = {2{wr_data_i[15:0]}};
            default:    wr_lanes_o = wr_data_i;
        endcase
    end

    // Shift the addressed lane down to bit 0 and mask off the rest. A
    // halfword offset is always 0 or 2, so the same shift covers both sizes.
    always_comb begin
        case (rd_size_i)
            HSIZE_BYTE: rd_data_o = (rd_lanes_i >> {rd_offset_i, 3'b000}) & 32'h0000_00FF;
            HSIZE_HALF: rd_data_o = (rd_lanes_i >> {rd_offset_i, 3'b000}) & 32'h0000_FFFF;
            default:    rd_data_o = rd_lanes_i;
        endcase
    end

endmodule

// File: rtl/ahb_lite_master.sv
// ---------------------------------------------------------------------------
// ahb_lite_master
// Turns a valid/ready request port into AHB-Lite single transfers and
// reports each completed transfer on a one-cycle response pulse. The address
// and data phases are pipelined, so a zero-wait slave sees one transfer
// per cycle.
//
// Ports
//   HCLK, HRESETn              : bus clock, asynchronous active-low reset
//   req_valid/req_ready        : request handshake
//   req_write/addr/size/wdata  : request contents (size > 2 is treated as word)
//   rsp_valid/write/rdata      : completed transfer, one cycle, no backpressure
//   HADDR/HTRANS/HSIZE/HWRITE  : AHB address phase
//   HWDATA                     : AHB write data (data phase)
//   HREADY/HRDATA              : AHB slave response
//   rsp_err                    : only with AHB_MASTER_TIMEOUT_EN
//
// Build option
//   AHB_MASTER_TIMEOUT_EN : flags a transfer whose data phase has waited
//   TIMEOUT_CYCLES cycles or more; its response carries rsp_err = 1 and
//   the filler data. Without the macro the master waits indefinitely.
// ---------------------------------------------------------------------------
module ahb_lite_master
    import ahb_pkg::*;
`ifdef AHB_MASTER_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
)
`endif
(
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_write,
    output logic [31:0] rsp_rdata,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HSIZE,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA
`ifdef AHB_MASTER_TIMEOUT_EN
    ,
    output logic        rsp_err
`endif
);

    // Address stage: these registers drive the bus address phase directly.
    logic        a_vld_q,   a_vld_d;
    logic [31:0] haddr_q,   haddr_d;
    logic [2:0]  hsize_q,   hsize_d;
    logic        hwrite_q,  hwrite_d;
    logic [31:0] a_wdata_q, a_wdata_d;

    // Data stage: context of the transfer whose data phase is on the bus.
    logic        d_vld_q,   d_vld_d;
    logic        d_write_q, d_write_d;
    logic [2:0]  d_size_q,  d_size_d;
    logic [1:0]  d_off_q,   d_off_d;
    logic [31:0] hwdata_q,  hwdata_d;

    // Response registers.
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_write_q, rsp_write_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic [31:0] wr_lanes;
    logic [31:0] rd_data;
    logic [2:0]  req_size_c;
    logic        xfer_done;

    assign req_ready  = ~a_vld_q | HREADY;
    assign req_size_c = clamp_size(req_size);
    assign xfer_done  = d_vld_q & HREADY;

    assign HADDR     = haddr_q;
    assign HTRANS    = a_vld_q ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HSIZE     = hsize_q;
    assign HWRITE    = hwrite_q;
    assign HWDATA    = hwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;

    ahb_lane_mux u_lane_mux (
        .wr_size_i   (hsize_q),
        .wr_data_i   (a_wdata_q),
        .wr_lanes_o  (wr_lanes),
        .rd_size_i   (d_size_q),
        .rd_offset_i (d_off_q),
        .rd_lanes_i  (HRDATA),
        .rd_data_o   (rd_data)
    );

`ifdef AHB_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             d_err_q,    d_err_d;
    logic             rsp_err_q,  rsp_err_d;

    assign rsp_err = rsp_err_q;

    // Wait-state counter for the current data phase. The bus cannot be
    // aborted, so reaching the limit only marks the transfer; the flag
    // travels with it until the slave finally completes.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        d_err_d    = d_err_q;
        rsp_err_d  = rsp_err_q;
        if (xfer_done) begin
            wait_cnt_d = '0;
            d_err_d    = 1'b0;
            rsp_err_d  = d_err_q;
        end else if (d_vld_q && !HREADY) begin
            if (wait_cnt_q != TMO_LIMIT) begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
            if (wait_cnt_d == TMO_LIMIT) begin
                d_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wait_cnt_q <= '0;
            d_err_q    <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            d_err_q    <= d_err_d;
            rsp_err_q  <= rsp_err_d;
        end
    end
`endif

    // Address stage: a new request is taken whenever the current address
    // phase is finished (or there is none). If nothing is offered at that
    // point the stage empties but the bus address/size/direction keep their
    // last values, so an IDLE bus does not toggle.
    always_comb begin
        a_vld_d   = a_vld_q;
        haddr_d   = haddr_q;
        hsize_d   = hsize_q;
        hwrite_d  = hwrite_q;
        a_wdata_d = a_wdata_q;
        if (req_ready) begin
            a_vld_d = req_valid;
            if (req_valid) begin
                haddr_d   = align_addr(req_addr, req_size_c);
                hsize_d   = req_size_c;
                hwrite_d  = req_write;
                a_wdata_d = req_wdata;
            end
        end
    end

    // Data stage: advances on every HREADY edge. The context is copied only
    // when a real address phase ends so HWDATA stays put across idle cycles.
    always_comb begin
        d_vld_d   = d_vld_q;
        d_write_d = d_write_q;
        d_size_d  = d_size_q;
        d_off_d   = d_off_q;
        hwdata_d  = hwdata_q;
        if (HREADY) begin
            d_vld_d = a_vld_q;
            if (a_vld_q) begin
                d_write_d = hwrite_q;
                d_size_d  = hsize_q;
                d_off_d   = haddr_q[1:0];
                hwdata_d  = wr_lanes;
            end
        end
    end

    // Response: one pulse per completed data phase; read data is captured
    // straight off HRDATA at the completing edge.
    always_comb begin
        rsp_valid_d = xfer_done;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        if (xfer_done) begin
            rsp_write_d = d_write_q;
            rsp_rdata_d = d_write_q ? 32'h0 : rd_data;
`ifdef AHB_MASTER_TIMEOUT_EN
            if (d_err_q) begin
                rsp_rdata_d = AHB_ERR_FILLER;
            end
`endif
        end
    end

    // All pipeline state clears at once on reset, which also drops any
    // transfer in flight without a response.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            a_vld_q     <= 1'b0;
            haddr_q     <= '0;
            hsize_q     <= '0;
            hwrite_q    <= 1'b0;
            a_wdata_q   <= '0;
            d_vld_q     <= 1'b0;
            d_write_q   <= 1'b0;
            d_size_q    <= '0;
            d_off_q     <= '0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            a_vld_q     <= a_vld_d;
            haddr_q     <= haddr_d;
            hsize_q     <= hsize_d;
            hwrite_q    <= hwrite_d;
            a_wdata_q   <= a_wdata_d;
            d_vld_q     <= d_vld_d;
            d_write_q   <= d_write_d;
            d_size_q    <= d_size_d;
            d_off_q     <= d_off_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_ahb_lite_master.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_master
// Directed bench for ahb_lite_master with a transaction-level reference
// model. Build with +define+AHB_MASTER_TIMEOUT_EN to include the timeout
// scenario (the DUT is then built with TIMEOUT_CYCLES = 8).
// ---------------------------------------------------------------------------
module tb_ahb_lite_master;

    localparam int TMO_CYCLES = 8;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
`ifdef AHB_MASTER_TIMEOUT_EN
    logic        rsp_err;
`endif

`ifdef AHB_MASTER_TIMEOUT_EN
    ahb_lite_master #(.TIMEOUT_CYCLES(TMO_CYCLES)) dut (
`else
    ahb_lite_master dut (
`endif
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA)
`ifdef AHB_MASTER_TIMEOUT_EN
        ,
        .rsp_err   (rsp_err)
`endif
    );

    always #5 HCLK = ~HCLK;

    int testsRun    = 0;
    int testsFailed = 0;
    int cyc         = 0;

    always @(posedge HCLK) cyc <= cyc + 1;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        logic        wr;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    typedef struct {
        int          cyc;
        logic        wr;
        logic [31:0] rdata;
        logic        err;
    } log_t;

    txn_t addrQ[$];
    txn_t dataQ[$];
    rsp_t expRspQ[$];
    log_t rspLog[$];

    int          curWaits    = 0;
    int          nonseqCnt   = 0;
    int          notReadyCnt = 0;
    logic [31:0] lastAddr    = 32'h0;
    logic [2:0]  lastSize    = 3'd0;
    logic        lastWrite   = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // Reference rules, stated arithmetically.
    function automatic logic [2:0] mSize(input logic [2:0] s);
        return (s > 3'd2) ? 3'd2 : s;
    endfunction

    function automatic logic [31:0] mAlign(input logic [31:0] a, input logic [2:0] s);
        if (s == 3'd0) return a;
        if (s == 3'd1) return a & ~32'h1;
        return a & ~32'h3;
    endfunction

    function automatic logic [31:0] mReplicate(input logic [31:0] w, input logic [2:0] s);
        if (s == 3'd0) return (w & 32'hFF) * 32'h0101_0101;
        if (s == 3'd1) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] mExtract(input logic [31:0] hr, input logic [31:0] a,
                                             input logic [2:0] s);
        if (s == 3'd0) return (hr >> (8 * (a % 4))) & 32'hFF;
        if (s == 3'd1) return ((a & 32'h2) != 0) ? (hr >> 16) : (hr & 32'hFFFF);
        return hr;
    endfunction

    // Reference model: tracks the accepted transfers through address phase,
    // data phase and response, and compares the bus every cycle.
    txn_t mT;
    rsp_t mR;
    log_t mL;
    always @(negedge HCLK) begin
        if (!HRESETn) begin
            addrQ.delete();
            dataQ.delete();
            expRspQ.delete();
            curWaits  = 0;
            lastAddr  = 32'h0;
            lastSize  = 3'd0;
            lastWrite = 1'b0;
        end else begin
            if (HTRANS == 2'b10) nonseqCnt++;
            if (!req_ready) notReadyCnt++;

            checkOutput("rsp_valid", {31'b0, rsp_valid}, {31'b0, expRspQ.size() != 0});
            if (rsp_valid) begin
                mL.cyc   = cyc;
                mL.wr    = rsp_write;
                mL.rdata = rsp_rdata;
`ifdef AHB_MASTER_TIMEOUT_EN
                mL.err   = rsp_err;
`else
                mL.err   = 1'b0;
`endif
                rspLog.push_back(mL);
            end
            if (expRspQ.size() != 0) begin
                mR = expRspQ.pop_front();
                if (rsp_valid) begin
                    checkOutput("rsp_write", {31'b0, rsp_write}, {31'b0, mR.wr});
                    checkOutput("rsp_rdata", rsp_rdata, mR.rdata);
`ifdef AHB_MASTER_TIMEOUT_EN
                    checkOutput("rsp_err", {31'b0, rsp_err}, {31'b0, mR.err});
`endif
                end
            end

            if (dataQ.size() != 0) begin
                if (dataQ[0].wr) begin
                    checkOutput("HWDATA", HWDATA, mReplicate(dataQ[0].wdata, dataQ[0].size));
                end
                if (HREADY) begin
                    mT       = dataQ.pop_front();
                    mR.wr    = mT.wr;
                    mR.rdata = mT.wr ? 32'h0 : mExtract(HRDATA, mT.addr, mT.size);
                    mR.err   = 1'b0;
`ifdef AHB_MASTER_TIMEOUT_EN
                    if (curWaits >= TMO_CYCLES) begin
                        mR.err   = 1'b1;
                        mR.rdata = 32'hDEADBEEF;
                    end
`endif
                    expRspQ.push_back(mR);
                    curWaits = 0;
                end else begin
                    curWaits++;
                end
            end

            checkOutput("req_ready", {31'b0, req_ready}, {31'b0, (addrQ.size() == 0) || HREADY});
            checkOutput("HTRANS", {30'b0, HTRANS}, (addrQ.size() != 0) ? 32'd2 : 32'd0);
            if (addrQ.size() != 0) begin
                checkOutput("HADDR", HADDR, addrQ[0].addr);
                checkOutput("HSIZE", {29'b0, HSIZE}, {29'b0, addrQ[0].size});
                checkOutput("HWRITE", {31'b0, HWRITE}, {31'b0, addrQ[0].wr});
                if (HREADY) dataQ.push_back(addrQ.pop_front());
            end else begin
                checkOutput("HADDR_idle", HADDR, lastAddr);
                checkOutput("HSIZE_idle", {29'b0, HSIZE}, {29'b0, lastSize});
                checkOutput("HWRITE_idle", {31'b0, HWRITE}, {31'b0, lastWrite});
            end

            if (req_valid && req_ready) begin
                mT.wr     = req_write;
                mT.size   = mSize(req_size);
                mT.addr   = mAlign(req_addr, mT.size);
                mT.wdata  = req_wdata;
                lastAddr  = mT.addr;
                lastSize  = mT.size;
                lastWrite = mT.wr;
                addrQ.push_back(mT);
            end
        end
    end

    // Offer one request and return just after the edge that accepts it.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                                 input logic [2:0] size, input logic [31:0] wdata,
                                 output int acceptEdge);
        logic rdy;
        int   tries;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_size  = size;
        req_wdata = wdata;
        rdy   = 1'b0;
        tries = 0;
        while (!rdy && tries < 64) begin
            @(negedge HCLK);
            rdy = req_ready;
            @(posedge HCLK);
            #1;
            tries++;
        end
        if (!rdy) checkOutput("accept_timeout", 32'd0, 32'd1);
        req_valid  = 1'b0;
        acceptEdge = cyc;
    endtask

    task automatic waitRsp(input int n);
        int k;
        k = 0;
        while (rspLog.size() < n && k < 40) begin
            @(posedge HCLK);
            #1;
            k++;
        end
        checkOutput("rsp_count", rspLog.size(), n);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    int acc, acc2, acc0, acc3;

    initial begin
        HRESETn   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'h0;
        req_size  = 3'd0;
        req_wdata = 32'h0;
        HREADY    = 1'b1;
        HRDATA    = 32'h0;

        #3;
        checkOutput("reset_req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("reset_HTRANS", {30'b0, HTRANS}, 32'd0);
        checkOutput("reset_HADDR", HADDR, 32'd0);
        checkOutput("reset_HWDATA", HWDATA, 32'd0);
        checkOutput("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        @(posedge HCLK);
        #1;

        // 1: zero-wait word read
        rspLog.delete();
        nonseqCnt = 0;
        HRDATA = 32'h1234_5678;
        applyStimulus(1'b0, 32'h40, 3'd2, 32'h0, acc);
        waitRsp(1);
        @(posedge HCLK);
        #1;
        checkOutput("t1_nonseq_cycles", nonseqCnt, 32'd1);
        checkOutput("t1_latency", 32'(rspLog[0].cyc - acc), 32'd2);
        checkOutput("t1_rdata", rspLog[0].rdata, 32'h1234_5678);

        // 2: byte write, then half write, byte read and oversize read
        rspLog.delete();
        HRDATA = 32'hFFFF_FFFF;
        applyStimulus(1'b1, 32'h103, 3'd0, 32'h0000_00A5, acc);
        @(negedge HCLK);
        checkOutput("t2_HADDR", HADDR, 32'h103);
        checkOutput("t2_HSIZE", {29'b0, HSIZE}, 32'd0);
        checkOutput("t2_HWRITE", {31'b0, HWRITE}, 32'd1);
        @(posedge HCLK);
        #1;
        @(negedge HCLK);
        checkOutput("t2_HWDATA", HWDATA, 32'hA5A5_A5A5);
        waitRsp(1);
        checkOutput("t2_rsp_write", {31'b0, rspLog[0].wr}, 32'd1);
        checkOutput("t2_rsp_rdata", rspLog[0].rdata, 32'd0);

        rspLog.delete();
        HRDATA = 32'h1122_3344;
        applyStimulus(1'b1, 32'h1E, 3'd1, 32'h0000_1234, acc);
        applyStimulus(1'b0, 32'h41, 3'd0, 32'h0, acc);
        applyStimulus(1'b0, 32'h47, 3'd5, 32'h0, acc);
        @(negedge HCLK);
        checkOutput("t2_clamp_HADDR", HADDR, 32'h44);
        checkOutput("t2_clamp_HSIZE", {29'b0, HSIZE}, 32'd2);
        waitRsp(3);
        checkOutput("t2_byte_rdata", rspLog[1].rdata, 32'h33);
        checkOutput("t2_word_rdata", rspLog[2].rdata, 32'h1122_3344);

        // 3: four back-to-back zero-wait reads
        rspLog.delete();
        notReadyCnt = 0;
        for (int i = 0; i < 4; i++) begin
            HRDATA = 32'hA000_0000 + i;
            applyStimulus(1'b0, 32'h100 + 4 * i, 3'd2, 32'h0, acc);
            if (i == 0) acc0 = acc;
            if (i == 3) acc3 = acc;
        end
        waitRsp(4);
        checkOutput("t3_accept_span", 32'(acc3 - acc0), 32'd3);
        checkOutput("t3_rsp_span", 32'(rspLog[3].cyc - rspLog[0].cyc), 32'd3);
        checkOutput("t3_not_ready", notReadyCnt, 32'd0);

        // 4: half read with 3 wait states, next address phase held meanwhile
        rspLog.delete();
        HRDATA = 32'h0;
        applyStimulus(1'b0, 32'h22, 3'd1, 32'h0, acc);
        applyStimulus(1'b0, 32'h80, 3'd2, 32'h0, acc2);
        HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            checkOutput("t4_hold_HADDR", HADDR, 32'h80);
            checkOutput("t4_hold_HTRANS", {30'b0, HTRANS}, 32'd2);
            checkOutput("t4_hold_HSIZE", {29'b0, HSIZE}, 32'd2);
            checkOutput("t4_hold_ready", {31'b0, req_ready}, 32'd0);
            @(posedge HCLK);
            #1;
        end
        HREADY = 1'b1;
        HRDATA = 32'hBEEF_0000;
        waitRsp(2);
        checkOutput("t4_half_rdata", rspLog[0].rdata, 32'h0000_BEEF);
        checkOutput("t4_latency", 32'(rspLog[0].cyc - acc), 32'd5);
        checkOutput("t4_word_rdata", rspLog[1].rdata, 32'hBEEF_0000);

        // 5: reset during a data phase
        rspLog.delete();
        applyStimulus(1'b1, 32'h200, 3'd2, 32'h55AA_55AA, acc);
        @(posedge HCLK);
        #2 HRESETn = 1'b0;
        #1;
        checkOutput("t5_HADDR", HADDR, 32'd0);
        checkOutput("t5_HWDATA", HWDATA, 32'd0);
        checkOutput("t5_HWRITE", {31'b0, HWRITE}, 32'd0);
        checkOutput("t5_HTRANS", {30'b0, HTRANS}, 32'd0);
        checkOutput("t5_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("t5_req_ready", {31'b0, req_ready}, 32'd1);
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        repeat (4) @(posedge HCLK);
        #1;
        checkOutput("t5_no_rsp", rspLog.size(), 32'd0);
        HRDATA = 32'hCAFE_F00D;
        applyStimulus(1'b0, 32'h44, 3'd2, 32'h0, acc);
        waitRsp(1);
        checkOutput("t5_after_rdata", rspLog[0].rdata, 32'hCAFE_F00D);

`ifdef AHB_MASTER_TIMEOUT_EN
        // 6: data phase stalled past the timeout
        rspLog.delete();
        HRDATA = 32'h1234_5678;
        applyStimulus(1'b0, 32'h10, 3'd2, 32'h0, acc);
        @(posedge HCLK);
        #1 HREADY = 1'b0;
        repeat (10) @(posedge HCLK);
        #1 HREADY = 1'b1;
        waitRsp(1);
        checkOutput("t6_rsp_err", {31'b0, rspLog[0].err}, 32'd1);
        checkOutput("t6_rdata", rspLog[0].rdata, 32'hDEAD_BEEF);
`endif

        repeat (3) @(posedge HCLK);
        #1;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
